// File: rtl/shiftreg_pkg.sv
// shiftreg_pkg
// Shared types for the multi-mode right-shift register:
//   mode_t  - manual operation selected by the 'mode' port while idle
//   state_t - auto-sequence controller states
package shiftreg_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD  = 2'd0,
    MODE_CLEAR = 2'd1,
    MODE_LOAD  = 2'd2,
    MODE_SHIFT = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/shiftreg_iter_cnt.sv
// shiftreg_iter_cnt
// Iteration counter for the auto shift sequence.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset (count -> 0)
//   clr  in   synchronous clear (count -> 0), below rst in priority
//   inc  in   count one step; the count saturates at NSTEP
//   cnt  out  current count (registered)
//   last out  count equals NSTEP-1, i.e. the next step completes the sequence
module shiftreg_iter_cnt #(
  parameter int NSTEP = 4,
  parameter int CNT_W = $clog2(NSTEP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt,
  output logic             last
);

  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(NSTEP);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NSTEP - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != CNT_MAX)) begin
      // Saturate instead of wrapping so a stray extra step cannot alias to 0.
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign last = (cnt_q == CNT_LAST);

endmodule

// File: rtl/shiftreg_mc.sv
// shiftreg_mc
// Multi-mode right-shift register holding the intermediate result of the
// Montgomery datapath. Manual ops (hold/clear/load/shift) while idle, plus a
// self-timed sequence: one load followed by WIDTH/SHIFT shift steps.
// Ports:
//   clk   in   clock
//   rst   in   synchronous active-high reset
//   ena   in   clock enable; when low all state holds (DONE still exits)
//   mode  in   manual op while idle: 0 hold, 1 clear, 2 load, 3 shift
//   start in   begin auto sequence (idle only, beats mode)
//   din   in   parallel load data
//   sin   in   serial fill bits entering at the MSB end
//   q     out  register contents
//   sout  out  bits most recently shifted out of the LSB end
//   iter  out  shift steps completed in the current/last auto sequence
//   busy  out  auto sequence running
//   done  out  one-cycle completion pulse
module shiftreg_mc
  import shiftreg_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHIFT = 1,
  localparam int NSTEP = WIDTH / SHIFT,
  localparam int CNT_W = $clog2(NSTEP + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ena,
  input  logic [1:0]       mode,
  input  logic             start,
  input  logic [WIDTH-1:0] din,
  input  logic [SHIFT-1:0] sin,
  output logic [WIDTH-1:0] q,
  output logic [SHIFT-1:0] sout,
  output logic [CNT_W-1:0] iter,
  output logic             busy,
  output logic             done
);

  if ((WIDTH < 2) || (SHIFT < 1) || (SHIFT >= WIDTH) || ((WIDTH % SHIFT) != 0)) begin : g_param_check
    $error("shiftreg_mc: need WIDTH>=2, 1<=SHIFT<WIDTH and WIDTH%%SHIFT==0");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [SHIFT-1:0] sout_q, sout_d;

  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_last;
  logic [CNT_W-1:0] cnt_val;

  mode_t            mode_op;
  logic [WIDTH-1:0] data_shifted;

  assign mode_op      = mode_t'(mode);
  // Serial bits enter at the MSB end; the bits falling off the LSB go to sout.
  assign data_shifted = {sin, data_q[WIDTH-1:SHIFT]};

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sout_d  = sout_q;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (ena) begin
          if (start) begin
            data_d  = din;
            cnt_clr = 1'b1;
            state_d = ST_RUN;
          end else begin
            case (mode_op)
              MODE_CLEAR: begin
                data_d  = '0;
                sout_d  = '0;
                cnt_clr = 1'b1;
              end
              MODE_LOAD: begin
                data_d = din;
              end
              MODE_SHIFT: begin
                data_d = data_shifted;
                sout_d = data_q[SHIFT-1:0];
              end
              default: begin
              end
            endcase
          end
        end
      end

      ST_RUN: begin
        if (ena) begin
          if (mode_op == MODE_CLEAR) begin
            // Abort: back to idle with a clean register and no done pulse.
            data_d  = '0;
            sout_d  = '0;
            cnt_clr = 1'b1;
            state_d = ST_IDLE;
          end else begin
            data_d  = data_shifted;
            sout_d  = data_q[SHIFT-1:0];
            cnt_inc = 1'b1;
            if (cnt_last) begin
              state_d = ST_DONE;
            end
          end
        end
      end

      ST_DONE: begin
        // The done pulse is exactly one cycle wide even if ena is low.
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      data_q  <= '0;
      sout_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sout_q  <= sout_d;
    end
  end

  shiftreg_iter_cnt #(
    .NSTEP (NSTEP),
    .CNT_W (CNT_W)
  ) u_iter_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (cnt_clr),
    .inc  (cnt_inc),
    .cnt  (cnt_val),
    .last (cnt_last)
  );

  assign q    = data_q;
  assign sout = sout_q;
  assign iter = cnt_val;
  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);

endmodule

// File: tb/tb_shiftreg_mc.sv
// tb_shiftreg_mc
// Randomised plus directed stimulus for shiftreg_mc (WIDTH=8, SHIFT=2).
// The driver advances a behavioural model each cycle and queues the expected
// outputs; an independent monitor pops and compares after every rising edge.
module tb_shiftreg_mc;

  localparam int WIDTH = 8;
  localparam int SHIFT = 2;
  localparam int NSTEP = WIDTH / SHIFT;
  localparam int CNT_W = $clog2(NSTEP + 1);

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             ena = 1'b0;
  logic [1:0]       mode = 2'd0;
  logic             start = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [SHIFT-1:0] sin = '0;
  logic [WIDTH-1:0] q;
  logic [SHIFT-1:0] sout;
  logic [CNT_W-1:0] iter;
  logic             busy;
  logic             done;

  shiftreg_mc #(.WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
    .clk   (clk),
    .rst   (rst),
    .ena   (ena),
    .mode  (mode),
    .start (start),
    .din   (din),
    .sin   (sin),
    .q     (q),
    .sout  (sout),
    .iter  (iter),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int sout;
    int iter;
    int busy;
    int done;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cycle_no = 0;

  // Behavioural model: phase 0 idle, 1 running, 2 done-pulse.
  int m_q = 0, m_sout = 0, m_iter = 0, m_phase = 0;

  function automatic void model_shift(input int s);
    m_sout = m_q % (1 << SHIFT);
    m_q    = (m_q >> SHIFT) + (s << (WIDTH - SHIFT));
  endfunction

  task automatic step(input bit r, input bit e, input int md, input bit st,
                      input int d, input int s);
    exp_t x;
    @(negedge clk);
    rst   = r;
    ena   = e;
    mode  = md[1:0];
    start = st;
    din   = d[WIDTH-1:0];
    sin   = s[SHIFT-1:0];
    if (r) begin
      m_q = 0; m_sout = 0; m_iter = 0; m_phase = 0;
    end else if (m_phase == 2) begin
      m_phase = 0;
    end else if (e && m_phase == 0) begin
      if (st) begin
        m_q = d; m_iter = 0; m_phase = 1;
      end else if (md == 1) begin
        m_q = 0; m_sout = 0; m_iter = 0;
      end else if (md == 2) begin
        m_q = d;
      end else if (md == 3) begin
        model_shift(s);
      end
    end else if (e && m_phase == 1) begin
      if (md == 1) begin
        m_q = 0; m_sout = 0; m_iter = 0; m_phase = 0;
      end else begin
        model_shift(s);
        if (m_iter < NSTEP) m_iter = m_iter + 1;
        if (m_iter == NSTEP) m_phase = 2;
      end
    end
    x.q    = m_q;
    x.sout = m_sout;
    x.iter = m_iter;
    x.busy = (m_phase == 1) ? 1 : 0;
    x.done = (m_phase == 2) ? 1 : 0;
    exp_q.push_back(x);
  endtask

  // Monitor: the register presents a new output state after every edge.
  always @(posedge clk) begin
    exp_t x;
    #1;
    cycle_no++;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      checks++;
      if (int'(q) != x.q || int'(sout) != x.sout || int'(iter) != x.iter ||
          int'(busy) != x.busy || int'(done) != x.done) begin
        failures++;
        $display("FAIL outputs cyc=%0d got q=%02h sout=%0d iter=%0d busy=%0d done=%0d want q=%02h sout=%0d iter=%0d busy=%0d done=%0d",
                 cycle_no, q, sout, iter, busy, done, x.q, x.sout, x.iter, x.busy, x.done);
      end else begin
        $display("cyc=%0d q=%02h sout=%0d iter=%0d busy=%0d done=%0d ok",
                 cycle_no, q, sout, iter, busy, done);
      end
    end
  end

  initial begin
    int waited;
    // Reset
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 8'hFF, 3);
    // LOAD 0xB4 then SHIFT with sin=11 -> 0xED, sout=00
    step(0, 1, 2, 0, 8'hB4, 0);
    step(0, 1, 3, 0, 0, 3);
    step(0, 1, 0, 0, 0, 0);
    // Auto run din=0x81, sin=0
    step(0, 1, 0, 1, 8'h81, 0);
    for (int i = 0; i < NSTEP + 2; i++) step(0, 1, 0, 0, 0, 0);
    // Same run with ena low for 3 cycles mid-sequence
    step(0, 1, 0, 1, 8'h81, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 3, 1, 8'h55, 1);
    for (int i = 0; i < NSTEP; i++) step(0, 1, 0, 0, 0, 0);
    // CLEAR during RUN at iter=1
    step(0, 1, 0, 1, 8'hC3, 2);
    step(0, 1, 3, 0, 0, 2);
    step(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0, 0);
    // start with mode=LOAD same cycle; start held through DONE
    step(0, 1, 2, 1, 8'h3C, 1);
    for (int i = 0; i < NSTEP + 3; i++) step(0, 1, 2, 1, 8'h99, 1);
    step(0, 1, 0, 0, 0, 0);
    // Reset mid-RUN: load 0xA5, two steps, then reset
    for (int i = 0; i < NSTEP + 2; i++) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 8'hA5, 1);
    step(0, 1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 4) != 0),
           int'($urandom_range(0, 3)), ($urandom_range(0, 9) == 0),
           int'($urandom_range(0, 255)), int'($urandom_range(0, 3)));
    end
    // Drain the scoreboard with a bounded wait.
    waited = 0;
    while (exp_q.size() > 0 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain got pending=%0d want pending=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
